// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped responder: peripheral base,
// register offsets and the seven-segment hex decode table.
package mmio_pkg;

    localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;

    localparam logic [11:0] DIG  = 12'h000;
    localparam logic [11:0] TMR  = 12'h020;
    localparam logic [11:0] TDIV = 12'h024;
    localparam logic [11:0] LED  = 12'h060;
    localparam logic [11:0] SW   = 12'h070;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}, decimal point off.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/mmio_responder_sw_debounce.sv
// Switch conditioner: two-flop synchronizer per bit followed by a single
// stability counter shared by all bits. The debounced value only updates
// once the whole synchronized vector has held still for DEB_CNT cycles.
module sw_debounce #(
    parameter int WIDTH   = 24,
    parameter int DEB_CNT = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] last;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;

    // Saturating increment so a long-stable input does not wrap the counter.
    always_comb begin
        cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end

    // Synchronize, restart the count on any change, accept once the count reaches its limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            last  <= '0;
            cnt   <= '0;
            deb   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            last  <= sync2;
            if (sync2 != last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_next;
                if (cnt_next == CNT_MAX) begin
                    deb <= sync2;
                end
            end
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// Data-bus responder for the CPU memory stage. Ordinary addresses pass
// through to data RAM; the top 4 KiB page serves LEDs, debounced switches,
// a scanned 8-digit seven-segment display and a prescaled free-running timer.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int DEB_CNT  = 500000,
    parameter int SCAN_DIV = 100000,
    parameter int TMR_DIV  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wr,
    output logic [31:0] rd,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    input  logic [23:0] device_sw,
    output logic [23:0] device_led,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_dn
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

    logic        is_periph;
    logic [11:0] off;
    logic        periph_we;
    logic        tick;

    logic [23:0]       led;
    logic [31:0]       digits;
    logic [31:0]       timer;
    logic [15:0]       tdiv;
    logic [15:0]       presc;
    logic [SCAN_W-1:0] scan;
    logic [2:0]        idx;
    logic [23:0]       sw_deb;

    assign is_periph = (addr[31:12] == PERIPH_BASE);
    assign off       = addr[11:0];
    assign periph_we = we && is_periph;

    assign mem_we   = we && !is_periph;
    assign mem_addr = addr;
    assign mem_wd   = wr;

    assign device_led = led;

    // A TDIV write restarts the prescaler, so it also suppresses the pending increment.
    assign tick = !(periph_we && off == TDIV) && (presc == tdiv);

    sw_debounce #(
        .WIDTH   (24),
        .DEB_CNT (DEB_CNT)
    ) u_sw_debounce (
        .clk (clk),
        .rst (rst),
        .raw (device_sw),
        .deb (sw_deb)
    );

    // LED and display-digit registers loaded by CPU stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            led    <= '0;
            digits <= '0;
        end else begin
            if (periph_we && off == LED) led    <= wr[23:0];
            if (periph_we && off == DIG) digits <= wr;
        end
    end

    // Prescaler and timer; a store to TMR overrides a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            tdiv  <= 16'(TMR_DIV - 1);
            presc <= '0;
            timer <= '0;
        end else begin
            if (periph_we && off == TDIV) begin
                tdiv  <= wr[15:0];
                presc <= '0;
            end else if (presc == tdiv) begin
                presc <= '0;
            end else begin
                presc <= presc + 16'd1;
            end

            if (periph_we && off == TMR) begin
                timer <= wr;
            end else if (tick) begin
                timer <= timer + 32'd1;
            end
        end
    end

    // Display scan: hold each digit for SCAN_DIV cycles, then move to the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan <= '0;
            idx  <= '0;
        end else if (scan == SCAN_MAX) begin
            scan <= '0;
            idx  <= idx + 3'd1;
        end else begin
            scan <= scan + SCAN_W'(1);
        end
    end

    // Active-low digit enable and segment pattern for the digit currently scanned.
    always_comb begin
        seg_en = ~(8'b1 << idx);
        seg_dn = hex_to_seg(digits[{idx, 2'b00} +: 4]);
    end

    // Zero-latency load data: RAM outside the peripheral page, registers inside it.
    always_comb begin
        rd = '0;
        if (!is_periph) begin
            rd = mem_rd;
        end else begin
            case (off)
                DIG:     rd = digits;
                TMR:     rd = timer;
                TDIV:    rd = {16'h0, tdiv};
                LED:     rd = {8'h0, led};
                SW:      rd = {8'h0, sw_deb};
                default: rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with short debounce, scan and timer
// periods. Inputs change on the falling edge; outputs are sampled shortly after.
module tb_mmio_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] wr = '0;
    logic [31:0] rd;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd = '0;
    logic [23:0] device_sw = '0;
    logic [23:0] device_led;
    logic [7:0]  seg_en;
    logic [7:0]  seg_dn;

    int errors = 0;
    int checks = 0;

    // Expected segment pattern per scan index for digits 0x12345678.
    logic [7:0] exp_seg [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    mmio_responder #(
        .DEB_CNT  (4),
        .SCAN_DIV (4),
        .TMR_DIV  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .we         (we),
        .wr         (wr),
        .rd         (rd),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .device_sw  (device_sw),
        .device_led (device_led),
        .seg_en     (seg_en),
        .seg_dn     (seg_dn)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    // One reset edge; returns on the falling edge right after release.
    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        we   = 1'b0;
        addr = '0;
        wr   = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present a store for exactly one rising edge.
    task automatic apply_store(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wr   = d;
        we   = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (device_led !== 24'h0) begin errors++; $display("[TB] FAIL reset_led: got %h expected %h", device_led, 24'h0); end
        checks++; if (seg_en !== 8'hFE) begin errors++; $display("[TB] FAIL reset_seg_en: got %h expected %h", seg_en, 8'hFE); end
        checks++; if (seg_dn !== 8'hC0) begin errors++; $display("[TB] FAIL reset_seg_dn: got %h expected %h", seg_dn, 8'hC0); end
        addr = 32'hFFFFF024; #1;
        checks++; if (rd !== 32'h2) begin errors++; $display("[TB] FAIL reset_tdiv: got %h expected %h", rd, 32'h2); end
        addr = 32'hFFFFF000; #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_dig: got %h expected %h", rd, 32'h0); end
        addr = 32'hFFFFF020; #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_tmr: got %h expected %h", rd, 32'h0); end
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk); #1;
            checks++;
            if (rd !== 32'(n / 3)) begin
                errors++;
                $display("[TB] FAIL timer_count_%0d: got %h expected %h", n, rd, 32'(n / 3));
            end
        end
    endtask

    task automatic test_led_ram();
        do_reset();
        mem_rd = 32'h13572468;
        addr = 32'hFFFFF060; wr = 32'h00ABCDEF; we = 1'b1; #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL led_store_mem_we: got %b expected %b", mem_we, 1'b0); end
        @(negedge clk); we = 1'b0; #1;
        checks++; if (device_led !== 24'hABCDEF) begin errors++; $display("[TB] FAIL led_out: got %h expected %h", device_led, 24'hABCDEF); end
        checks++; if (rd !== 32'h00ABCDEF) begin errors++; $display("[TB] FAIL led_read: got %h expected %h", rd, 32'h00ABCDEF); end
        @(negedge clk);
        addr = 32'h00000010; wr = 32'hDEADBEEF; we = 1'b1; #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL ram_mem_we: got %b expected %b", mem_we, 1'b1); end
        checks++; if (mem_addr !== 32'h00000010) begin errors++; $display("[TB] FAIL ram_mem_addr: got %h expected %h", mem_addr, 32'h10); end
        checks++; if (mem_wd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL ram_mem_wd: got %h expected %h", mem_wd, 32'hDEADBEEF); end
        checks++; if (rd !== 32'h13572468) begin errors++; $display("[TB] FAIL ram_read: got %h expected %h", rd, 32'h13572468); end
        @(negedge clk); we = 1'b0; #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL ram_mem_we_drop: got %b expected %b", mem_we, 1'b0); end
        checks++; if (device_led !== 24'hABCDEF) begin errors++; $display("[TB] FAIL ram_led_kept: got %h expected %h", device_led, 24'hABCDEF); end
        @(negedge clk);
        apply_store(32'hFFFFF070, 32'hFFFFFFFF);
        apply_store(32'hFFFFF064, 32'h55555555);
        #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read: got %h expected %h", rd, 32'h0); end
        addr = 32'hFFFFF070; #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL sw_write_ignored: got %h expected %h", rd, 32'h0); end
        addr = 32'hFFFFF060; #1;
        checks++; if (rd !== 32'h00ABCDEF) begin errors++; $display("[TB] FAIL led_after_ignored: got %h expected %h", rd, 32'h00ABCDEF); end
        mem_rd = '0;
    endtask

    task automatic test_switches();
        logic [31:0] exp;
        do_reset();
        repeat (6) @(negedge clk);
        addr = 32'hFFFFF070;
        device_sw = 24'h00000F;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk); #1;
            exp = (n >= 6) ? 32'h0000000F : 32'h0;
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("[TB] FAIL debounce_cycle_%0d: got %h expected %h", n, rd, exp);
            end
        end
        @(negedge clk);
        device_sw = 24'h00001F;
        @(negedge clk);
        device_sw = 24'h00000F;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk); #1;
            checks++;
            if (rd !== 32'h0000000F) begin
                errors++;
                $display("[TB] FAIL glitch_cycle_%0d: got %h expected %h", n, rd, 32'h0000000F);
            end
        end
    endtask

    task automatic test_display();
        int k;
        do_reset();
        apply_store(32'hFFFFF000, 32'h12345678);
        #1;
        checks++; if (rd !== 32'h12345678) begin errors++; $display("[TB] FAIL dig_read: got %h expected %h", rd, 32'h12345678); end
        for (int n = 1; n <= 32; n++) begin
            k = (n / 4) % 8;
            checks++;
            if (seg_en !== ~(8'd1 << k)) begin
                errors++;
                $display("[TB] FAIL scan_en_%0d: got %h expected %h", n, seg_en, ~(8'd1 << k));
            end
            checks++;
            if (seg_dn !== exp_seg[k]) begin
                errors++;
                $display("[TB] FAIL scan_dn_%0d: got %h expected %h", n, seg_dn, exp_seg[k]);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_timer();
        logic [31:0] exp;
        do_reset();
        repeat (2) @(negedge clk);
        apply_store(32'hFFFFF020, 32'hFFFFFFFF);
        #1;
        checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL tmr_write_wins: got %h expected %h", rd, 32'hFFFFFFFF); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            exp = (k < 3) ? 32'hFFFFFFFF : 32'h0;
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("[TB] FAIL tmr_wrap_%0d: got %h expected %h", k, rd, exp);
            end
        end
        do_reset();
        apply_store(32'hFFFFF024, 32'h0);
        #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL tdiv_zero_read: got %h expected %h", rd, 32'h0); end
        addr = 32'hFFFFF020; #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL tdiv_zero_tmr1: got %h expected %h", rd, 32'h0); end
        for (int n = 2; n <= 5; n++) begin
            @(negedge clk); #1;
            checks++;
            if (rd !== 32'(n - 1)) begin
                errors++;
                $display("[TB] FAIL tdiv_zero_tmr%0d: got %h expected %h", n, rd, 32'(n - 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        apply_store(32'hFFFFF060, 32'hFF111111);
        apply_store(32'hFFFFF000, 32'h0000000A);
        apply_store(32'hFFFFF024, 32'hABCD1234);
        #1;
        checks++; if (device_led !== 24'h111111) begin errors++; $display("[TB] FAIL b2b_led_out: got %h expected %h", device_led, 24'h111111); end
        checks++; if (seg_dn !== 8'h88) begin errors++; $display("[TB] FAIL b2b_seg_dn: got %h expected %h", seg_dn, 8'h88); end
        checks++; if (rd !== 32'h00001234) begin errors++; $display("[TB] FAIL b2b_tdiv: got %h expected %h", rd, 32'h00001234); end
        addr = 32'hFFFFF060; #1;
        checks++; if (rd !== 32'h00111111) begin errors++; $display("[TB] FAIL b2b_led: got %h expected %h", rd, 32'h00111111); end
        addr = 32'hFFFFF000; #1;
        checks++; if (rd !== 32'h0000000A) begin errors++; $display("[TB] FAIL b2b_dig: got %h expected %h", rd, 32'h0000000A); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        apply_store(32'hFFFFF060, 32'h00FF00FF);
        apply_store(32'hFFFFF000, 32'h87654321);
        device_sw = 24'h000005;
        addr = 32'hFFFFF070;
        repeat (8) @(negedge clk);
        #1;
        checks++; if (rd !== 32'h5) begin errors++; $display("[TB] FAIL midop_sw: got %h expected %h", rd, 32'h5); end
        checks++; if (seg_en !== 8'hFB) begin errors++; $display("[TB] FAIL midop_seg_en: got %h expected %h", seg_en, 8'hFB); end
        checks++; if (seg_dn !== 8'hB0) begin errors++; $display("[TB] FAIL midop_seg_dn: got %h expected %h", seg_dn, 8'hB0); end
        checks++; if (device_led !== 24'hFF00FF) begin errors++; $display("[TB] FAIL midop_led: got %h expected %h", device_led, 24'hFF00FF); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (device_led !== 24'h0) begin errors++; $display("[TB] FAIL rst_led: got %h expected %h", device_led, 24'h0); end
        checks++; if (seg_en !== 8'hFE) begin errors++; $display("[TB] FAIL rst_seg_en: got %h expected %h", seg_en, 8'hFE); end
        checks++; if (seg_dn !== 8'hC0) begin errors++; $display("[TB] FAIL rst_seg_dn: got %h expected %h", seg_dn, 8'hC0); end
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rst_sw: got %h expected %h", rd, 32'h0); end
        addr = 32'hFFFFF020; #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rst_tmr: got %h expected %h", rd, 32'h0); end
        device_sw = '0;
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] mmio_responder directed tests");
        test_reset();
        test_led_ram();
        test_switches();
        test_display();
        test_timer();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
